vga_pattern_source: RTL and testbench
=====================================

// Module: vga_pattern_source
// PURPOSE
//   VGA timing plus test-pattern video source. Free-running column/row counters produce active-high
//   HSync/VSync, and a pattern selector drives R/G/B video aligned to those syncs.
//   Feeds the porch/sync-shaping stage (VGA_Sync_Porch) in the display path.
// PARAMETERS
//   VIDEO_WIDTH  3    bits per colour channel; "full" = all ones
//   TOTAL_COLS   800  columns per line, active plus blanking
//   TOTAL_ROWS   525  rows per frame, active plus blanking
//   ACTIVE_COLS  640  visible columns; must be a multiple of 8
//   ACTIVE_ROWS  480  visible rows
//   CHECK_SHIFT  5    checkerboard square = 2**CHECK_SHIFT pixels
//   BORDER_W     2    border thickness in pixels (pattern 6)
// PORTS
//   i_Clk        in   1            pixel clock; all logic on rising edge
//   i_Rst        in   1            reset: synchronous, active-high
//   i_Pattern    in   4            pattern select, sampled every cycle
//   o_HSync      out  1            1 while column < ACTIVE_COLS
//   o_VSync      out  1            1 while row < ACTIVE_ROWS
//   o_Col_Count  out  10           column of current output pixel
//   o_Row_Count  out  10           row of current output pixel
//   o_Red_Video  out  VIDEO_WIDTH  red channel
//   o_Grn_Video  out  VIDEO_WIDTH  green channel
//   o_Blu_Video  out  VIDEO_WIDTH  blue channel
// BEHAVIOUR
//   Stage 0 (counters):
//   - col increments each clock; at TOTAL_COLS-1 it wraps to 0 and row increments
//   - row wraps 0 after TOTAL_ROWS-1 on the same edge col wraps; frame = TOTAL_COLS*TOTAL_ROWS clocks
//   Stage 1 (registered outputs): sync, counts and video are all computed from the stage-0 values.
//   - Latency: 1 clock from counter to outputs. Syncs, counts and video are mutually cycle-aligned.
//   Reset:
//   - While i_Rst=1, counters are forced to 0 and every output is registered to 0.
//   - On the first edge with i_Rst=0, the outputs show col 0/row 0 (o_HSync=1, o_VSync=1) and
//     the counter moves to col 1.
//   - Reset mid-frame restarts at col 0/row 0 with no partial-line recovery.
//   Blanking: video = 0 whenever col >= ACTIVE_COLS or row >= ACTIVE_ROWS, for every pattern.
//   Patterns (value F = all ones, active area only):
//   - 0: all black
//   - 1: red F
//   - 2: green F
//   - 3: blue F
//   - 4: checkerboard; white(F,F,F) when col[CHECK_SHIFT]^row[CHECK_SHIFT]=1, else black
//   - 5: colour bars; k = col/(ACTIVE_COLS/8), clamped to 7; R=F*k[2], G=F*k[1], B=F*k[0]
//        (bar order: black, blue, green, cyan, red, magenta, yellow, white)
//   - 6: white border; F,F,F when col<BORDER_W, col>=ACTIVE_COLS-BORDER_W, row<BORDER_W
//        or row>=ACTIVE_ROWS-BORDER_W; black inside
//   - 7..15: black
//   i_Pattern changes apply to the next output pixel; there is no frame-boundary gating.
//   Counter widths: 10 bits. TOTAL_COLS and TOTAL_ROWS must be <= 1024. No arithmetic overflow.
// STRUCTURE
//   Package vga_pkg: pattern-code localparams (PAT_BLACK..PAT_BORDER) and the count width (10).
//   Sub-module vga_sync_counter holds the stage-0 counters and raw syncs.
//   The top level registers stage 1 with a pattern case mux.
// TESTING (VIDEO_WIDTH=2, TOTAL 10x6, ACTIVE 8x4, 40 ns clock)
//   - Reset 3 clocks, then release -> the first output has col 0/row 0 with HSync=VSync=1.
//     HSync is high for 8 clocks and low for 2; VSync is high for 40 clocks and low for 20;
//     period is 60 clocks.
//   - Pattern 5 -> row 0, cols 0..7 give RGB (0,0,0),(0,0,3),(0,3,0),(0,3,3),(3,0,0),(3,0,3),(3,3,0),(3,3,3).
//     Cols 8,9 give 0.
//   - Patterns 1/2/3 -> only that channel = 3 across the 8x4 active area; 0 in blanking and rows 4,5.
//   - Pattern 6 with BORDER_W=2 -> rows 0,1,2,3 and cols 0,1,6,7 are white. With 4 rows, every active
//     pixel is white. Set ACTIVE_ROWS=6 and TOTAL_ROWS=8: rows 2,3 at cols 2..5 are black.
//   - Assert i_Rst for 1 clock at col 5/row 2 -> the next output is 0. After release, the sequence
//     restarts at col 0/row 0.
//   - Switch i_Pattern 5->0 mid-line -> the very next output pixel is black.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern source: counter width and pattern codes.
package vga_pkg;
  localparam int CNT_W = 10;

  localparam logic [3:0] PAT_BLACK  = 4'd0;
  localparam logic [3:0] PAT_RED    = 4'd1;
  localparam logic [3:0] PAT_GRN    = 4'd2;
  localparam logic [3:0] PAT_BLU    = 4'd3;
  localparam logic [3:0] PAT_CHECK  = 4'd4;
  localparam logic [3:0] PAT_BARS   = 4'd5;
  localparam logic [3:0] PAT_BORDER = 4'd6;
endpackage

// File: rtl/vga_sync_counter.sv
// Stage-0 free-running column/row counters with raw (unregistered) active-area syncs.
import vga_pkg::*;

module vga_sync_counter #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             hsync,
  output logic             vsync
);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col <= '0;
      row <= '0;
    end else if (col == COL_LAST) begin
      col <= '0;
      row <= (row == ROW_LAST) ? '0 : row + 1'b1;
    end else begin
      col <= col + 1'b1;
    end
  end

  assign hsync = (col < CNT_W'(ACTIVE_COLS));
  assign vsync = (row < CNT_W'(ACTIVE_ROWS));
endmodule

// File: rtl/vga_pattern_source.sv
// VGA timing plus test-pattern source; stage 1 registers syncs, counts and video
// together so all outputs stay cycle-aligned one clock behind the counters.
import vga_pkg::*;

module vga_pattern_source #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int CHECK_SHIFT = 5,
  parameter int BORDER_W    = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [3:0]             i_Pattern,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [CNT_W-1:0]       o_Col_Count,
  output logic [CNT_W-1:0]       o_Row_Count,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);
  localparam int BAR_W = ACTIVE_COLS / 8;
  localparam logic [VIDEO_WIDTH-1:0] FULL = '1;

  logic [CNT_W-1:0]       col, row;
  logic                   hsync, vsync, active, border;
  logic [2:0]             bar;
  logic [VIDEO_WIDTH-1:0] red, grn, blu;

  vga_sync_counter #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS),
    .ACTIVE_COLS(ACTIVE_COLS),
    .ACTIVE_ROWS(ACTIVE_ROWS)
  ) u_cnt (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .col  (col),
    .row  (row),
    .hsync(hsync),
    .vsync(vsync)
  );

  assign active = hsync & vsync;
  assign border = (col <  CNT_W'(BORDER_W)) ||
                  (col >= CNT_W'(ACTIVE_COLS - BORDER_W)) ||
                  (row <  CNT_W'(BORDER_W)) ||
                  (row >= CNT_W'(ACTIVE_ROWS - BORDER_W));

  // Bar index by threshold compares avoids a divider when BAR_W is not a power of two.
  always_comb begin
    bar = '0;
    for (int i = 1; i < 8; i++)
      if (col >= CNT_W'(i * BAR_W)) bar = 3'(i);
  end

  always_comb begin
    red = '0;
    grn = '0;
    blu = '0;
    if (active) begin
      case (i_Pattern)
        PAT_RED: red = FULL;
        PAT_GRN: grn = FULL;
        PAT_BLU: blu = FULL;
        PAT_CHECK:
          if (col[CHECK_SHIFT] ^ row[CHECK_SHIFT]) begin
            red = FULL;
            grn = FULL;
            blu = FULL;
          end
        PAT_BARS: begin
          red = {VIDEO_WIDTH{bar[2]}};
          grn = {VIDEO_WIDTH{bar[1]}};
          blu = {VIDEO_WIDTH{bar[0]}};
        end
        PAT_BORDER:
          if (border) begin
            red = FULL;
            grn = FULL;
            blu = FULL;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_HSync     <= 1'b0;
      o_VSync     <= 1'b0;
      o_Col_Count <= '0;
      o_Row_Count <= '0;
      o_Red_Video <= '0;
      o_Grn_Video <= '0;
      o_Blu_Video <= '0;
    end else begin
      o_HSync     <= hsync;
      o_VSync     <= vsync;
      o_Col_Count <= col;
      o_Row_Count <= row;
      o_Red_Video <= red;
      o_Grn_Video <= grn;
      o_Blu_Video <= blu;
    end
  end
endmodule

// File: tb/tb_vga_pattern_source.sv
// Directed bench: 10x6 frame (8x4 active) on DUT a, 10x8 frame (8x6 active) on DUT b for the border.
module tb_vga_pattern_source;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pat = 4'd0;

  logic       a_hs, a_vs, b_hs, b_vs;
  logic [9:0] a_col, a_row, b_col, b_row;
  logic [1:0] a_r, a_g, a_b, b_r, b_g, b_b;

  int checks = 0;
  int errors = 0;
  int pos    = 0;  // frame index of the pixel the next edge outputs on DUT a
  int posb   = 0;  // same for DUT b

  always #20 clk = ~clk;

  vga_pattern_source #(
    .VIDEO_WIDTH(2), .TOTAL_COLS(10), .TOTAL_ROWS(6), .ACTIVE_COLS(8), .ACTIVE_ROWS(4),
    .CHECK_SHIFT(1), .BORDER_W(2)
  ) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Pattern(pat),
    .o_HSync(a_hs), .o_VSync(a_vs), .o_Col_Count(a_col), .o_Row_Count(a_row),
    .o_Red_Video(a_r), .o_Grn_Video(a_g), .o_Blu_Video(a_b)
  );

  vga_pattern_source #(
    .VIDEO_WIDTH(2), .TOTAL_COLS(10), .TOTAL_ROWS(8), .ACTIVE_COLS(8), .ACTIVE_ROWS(6),
    .CHECK_SHIFT(1), .BORDER_W(2)
  ) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Pattern(4'd6),
    .o_HSync(b_hs), .o_VSync(b_vs), .o_Col_Count(b_col), .o_Row_Count(b_row),
    .o_Red_Video(b_r), .o_Grn_Video(b_g), .o_Blu_Video(b_b)
  );

  typedef struct {
    int pat; int col; int row; int hs; int vs; int r; int g; int b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int p, input int c, input int rw, input int hs, input int vs,
                     input int r, input int g, input int b);
    vec_t v;
    v.pat = p; v.col = c; v.row = rw; v.hs = hs; v.vs = vs; v.r = r; v.g = g; v.b = b;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pos  = (pos + 1) % 60;
    posb = (posb + 1) % 80;
  endtask

  task automatic goto_a(input int c, input int rw);
    while (pos != rw * 10 + c) step();
  endtask

  string bmp[6];

  initial begin
    // Hand-computed vectors for DUT a (F = 3, bar width 1, checker on bit 1).
    add(5,0,0,1,1,0,0,0); add(5,1,0,1,1,0,0,3); add(5,2,0,1,1,0,3,0); add(5,3,0,1,1,0,3,3);
    add(5,4,0,1,1,3,0,0); add(5,5,0,1,1,3,0,3); add(5,6,0,1,1,3,3,0); add(5,7,0,1,1,3,3,3);
    add(5,8,0,0,1,0,0,0); add(5,9,0,0,1,0,0,0); add(5,3,2,1,1,0,3,3); add(5,7,4,1,0,0,0,0);
    add(1,2,1,1,1,3,0,0); add(1,9,1,0,1,0,0,0); add(1,3,4,1,0,0,0,0);
    add(2,7,3,1,1,0,3,0); add(2,0,5,1,0,0,0,0);
    add(3,4,2,1,1,0,0,3); add(3,8,0,0,1,0,0,0);
    add(4,0,0,1,1,0,0,0); add(4,2,0,1,1,3,3,3); add(4,2,2,1,1,0,0,0); add(4,1,3,1,1,3,3,3);
    add(4,2,5,1,0,0,0,0);
    add(6,3,2,1,1,3,3,3); add(6,9,0,0,1,0,0,0);
    add(0,3,1,1,1,0,0,0); add(9,3,1,1,1,0,0,0); add(15,5,2,1,1,0,0,0);

    bmp[0] = "11111111"; bmp[1] = "11111111"; bmp[2] = "11000011";
    bmp[3] = "11000011"; bmp[4] = "11111111"; bmp[5] = "11111111";

    // Reset for 3 clocks: all outputs zero.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_hs",  a_hs, 0);  chk("rst_vs", a_vs, 0);
      chk("rst_col", a_col, 0); chk("rst_row", a_row, 0);
      chk("rst_red", a_r, 0);
    end
    rst = 1'b0;
    pat = 4'd5;
    pos = 0; posb = 0;

    // One full frame of sync/count timing.
    begin
      int hs_hi, vs_hi;
      hs_hi = 0; vs_hi = 0;
      for (int k = 0; k < 60; k++) begin
        step();
        chk("frm_col", a_col, k % 10);
        chk("frm_row", a_row, k / 10);
        chk("frm_hs",  a_hs, (k % 10) < 8 ? 1 : 0);
        chk("frm_vs",  a_vs, (k / 10) < 4 ? 1 : 0);
        hs_hi += a_hs; vs_hi += a_vs;
      end
      chk("hs_high_total", hs_hi, 48);
      chk("vs_high_total", vs_hi, 40);
      step();
      chk("wrap_col", a_col, 0);
      chk("wrap_row", a_row, 0);
    end

    // Table-driven pattern vectors.
    foreach (tbl[i]) begin
      goto_a(tbl[i].col, tbl[i].row);
      pat = 4'(tbl[i].pat);
      step();
      chk($sformatf("v%0d_col", i), a_col, tbl[i].col);
      chk($sformatf("v%0d_row", i), a_row, tbl[i].row);
      chk($sformatf("v%0d_hs", i),  a_hs,  tbl[i].hs);
      chk($sformatf("v%0d_vs", i),  a_vs,  tbl[i].vs);
      chk($sformatf("v%0d_r", i),   a_r,   tbl[i].r);
      chk($sformatf("v%0d_g", i),   a_g,   tbl[i].g);
      chk($sformatf("v%0d_b", i),   a_b,   tbl[i].b);
    end

    // Pattern switch mid-line takes effect on the very next pixel.
    pat = 4'd5;
    goto_a(3, 1);
    step();
    chk("sw_before_g", a_g, 3);
    chk("sw_before_b", a_b, 3);
    pat = 4'd0;
    step();
    chk("sw_after_col", a_col, 4);
    chk("sw_after_r",   a_r, 0);
    chk("sw_after_g",   a_g, 0);
    chk("sw_after_b",   a_b, 0);

    // Border on the taller frame of DUT b.
    while (posb != 0) step();
    for (int k = 0; k < 80; k++) begin
      int c, rw, w;
      c = k % 10; rw = k / 10;
      step();
      w = (c < 8 && rw < 6 && bmp[rw][c] == "1") ? 3 : 0;
      chk($sformatf("brd_r_%0d_%0d", c, rw), b_r, w);
      chk($sformatf("brd_b_%0d_%0d", c, rw), b_b, w);
      chk($sformatf("brd_col_%0d", k), b_col, c);
      chk($sformatf("brd_row_%0d", k), b_row, rw);
    end

    // One-clock reset at col 5 / row 2, then restart from col 0 / row 0.
    pat = 4'd1;
    goto_a(5, 2);
    rst = 1'b1;
    step();
    chk("mrst_hs",  a_hs, 0);  chk("mrst_vs",  a_vs, 0);
    chk("mrst_col", a_col, 0); chk("mrst_row", a_row, 0);
    chk("mrst_red", a_r, 0);   chk("mrst_b_red", b_r, 0);
    rst = 1'b0;
    pos = 0; posb = 0;
    step();
    chk("rel_col", a_col, 0); chk("rel_row", a_row, 0);
    chk("rel_hs",  a_hs, 1);  chk("rel_vs",  a_vs, 1);
    chk("rel_red", a_r, 3);
    step();
    chk("rel2_col", a_col, 1); chk("rel2_row", a_row, 0);
    step();
    chk("rel3_col", a_col, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
